tracer_host: RTL and testbench



---
 rtl/tracer_host_pkg.sv | 18 +
 rtl/tracer_host_nibble_serializer.sv | 39 +++
 rtl/tracer_host.sv | 104 ++++++++++
 tb/tb_tracer_host.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tracer_host_pkg.sv
// Shared types and constants for the tracer nibble-protocol host.
package tracer_host_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    CALC = 3'd2,
    HI   = 3'd3,
    LO   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int NIBBLES    = 4;
  localparam int NIB_W      = 4;
  localparam int RESP_BYTES = 2;
  localparam int LATENCY    = 7;

endpackage

// File: rtl/tracer_host_nibble_serializer.sv
// Loads an operand and presents it MSB nibble first; nib shows the nibble to
// drive next (the load data itself on the load cycle), last flags the final one.
module nibble_serializer
  import tracer_host_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [W-1:0]     data,
  output logic [NIB_W-1:0] nib,
  output logic             last
);

  localparam int CW = $clog2(N);

  logic [W-1:0]  shreg;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= data << NIB_W;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= shreg << NIB_W;
      cnt   <= cnt + CW'(1);
    end
  end

  assign nib  = load ? data[W-1 -: NIB_W] : shreg[W-1 -: NIB_W];
  assign last = (cnt == CW'(N - 1));

endmodule

// File: rtl/tracer_host.sv
// Initiator for the tracer reciprocal responder: serialises a Q6.10 operand,
// collects the two result bytes. Optional macro: TRACER_HOST_OVERLAP_EN.
module tracer_host #(
  parameter int OPERAND_W = 16,
  parameter int NIBBLES   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OPERAND_W-1:0] req_operand,
  input  logic                 req_abs,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [OPERAND_W-1:0] rsp_data,
  output logic                 dut_reset,
  output logic                 dut_abs,
  output logic [3:0]           dut_data,
  input  logic [7:0]           dut_out,
  output logic [2:0]           dbg_state
);
  import tracer_host_pkg::*;

  // Handshakes: a beat transfers on the rising clk edge where valid && ready;
  // valid never depends on ready, and a raised rsp_valid holds until taken.
  state_t     state, next_state;
  logic       accept, shift, cap_hi, cap_lo, ser_last;
  logic [3:0] ser_nib;

  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  nibble_serializer #(.W(OPERAND_W), .N(NIBBLES)) u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (shift),
    .data  (req_operand),
    .nib   (ser_nib),
    .last  (ser_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SEND;
      SEND:    if (ser_last) next_state = CALC;
      CALC:    next_state = HI;
      HI:      next_state = LO;
      LO:      next_state = DONE;
      DONE:    if (rsp_ready) next_state = accept ? SEND : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    shift     = 1'b0;
    cap_hi    = 1'b0;
    cap_lo    = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      SEND: shift     = !ser_last;
      HI:   cap_hi    = 1'b1;
      LO:   cap_lo    = 1'b1;
      DONE: begin
        rsp_valid = 1'b1;
`ifdef TRACER_HOST_OVERLAP_EN
        req_ready = rsp_ready;
`else
        req_ready = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // Responder pins are registered from next_state so they line up with the
  // state they belong to; the responder idles at step 0 while held in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dut_reset <= 1'b1;
      dut_abs   <= 1'b0;
      dut_data  <= '0;
      rsp_data  <= '0;
    end else begin
      dut_reset <= (next_state == IDLE) || (next_state == DONE);
      dut_data  <= (accept || shift) ? ser_nib : 4'd0;
      if (accept)
        dut_abs <= req_abs;
      else if ((next_state == IDLE) || (next_state == DONE))
        dut_abs <= 1'b0;
      if (cap_hi) rsp_data[OPERAND_W-1 -: 8] <= dut_out;
      if (cap_lo) rsp_data[7:0]              <= dut_out;
    end
  end

endmodule

// File: tb/tb_tracer_host.sv
// Bench for tracer_host with a behavioural tracer reciprocal responder attached.
module tb_tracer_host;
  import tracer_host_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_abs, rsp_ready;
  logic [15:0] req_operand;
  logic        req_ready, rsp_valid, dut_reset, dut_abs;
  logic [15:0] rsp_data;
  logic [3:0]  dut_data;
  logic [7:0]  dut_out;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] exp_q[$];
  int          acc_q[$];

  tracer_host #(.OPERAND_W(16), .NIBBLES(NIBBLES)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_operand (req_operand),
    .req_abs     (req_abs),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .dut_reset   (dut_reset),
    .dut_abs     (dut_abs),
    .dut_data    (dut_data),
    .dut_out     (dut_out),
    .dbg_state   (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Q6.10 reciprocal reference: 2^20 / x, saturating, abs mode folds the sign.
  function automatic logic [15:0] recip_ref(input logic [15:0] op, input logic ab);
    int mag, q;
    logic neg;
    neg = op[15];
    mag = neg ? (65536 - int'(op)) : int'(op);
    if (mag == 0) q = 32767;
    else begin
      q = (1 << 20) / mag;
      if (q > 32767) q = 32767;
    end
    if (neg && !ab) q = -q;
    return q[15:0];
  endfunction

  // behavioural responder: 6-step cycle, nibbles at steps 0-3, result at 4,
  // high byte visible at step 5, low byte at step 0
  logic [2:0]  rstep = 3'd0;
  logic [15:0] rsh   = 16'd0;
  logic [15:0] rres  = 16'd0;

  always @(posedge clk) begin
    if (dut_reset) rstep <= 3'd0;
    else begin
      rstep <= (rstep == 3'd5) ? 3'd0 : rstep + 3'd1;
      if (rstep < 3'd4) rsh <= {rsh[11:0], dut_data};
      if (rstep == 3'd4) rres <= recip_ref(rsh, dut_abs);
    end
  end
  assign dut_out = (rstep == 3'd5) ? rres[15:8] : rres[7:0];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard / monitor
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rsp_valid && !prev_valid) begin
      if (acc_q.size() == 0) check_val("latency_no_accept", 32'd1, 32'd0);
      else check_val("latency", 32'(cyc - acc_q.pop_front()), 32'(LATENCY));
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check_val("rsp_unexpected", {16'd0, rsp_data}, 32'hDEAD);
      else check_val("rsp_data", {16'd0, rsp_data}, {16'd0, exp_q.pop_front()});
    end
    prev_valid = rsp_valid;
  end

  // driver tasks
  task automatic drive_req(input logic [15:0] op, input logic ab, input logic [15:0] exp,
                           input bit keep, output int acc_edge);
    bit got = 1'b0;
    acc_edge = -1;
    @(negedge clk);
    req_operand = op;
    req_abs     = ab;
    req_valid   = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      if (req_ready) begin
        exp_q.push_back(exp);
        acc_edge = cyc + 1;
        acc_q.push_back(acc_edge);
        @(posedge clk);
        #1;
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) check_val("req_accept_timeout", 32'd0, 32'd1);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check_val("rsp_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  logic [3:0]  nib_exp [4];
  int          e0, e1;
  logic [15:0] op;
  logic        ab;
  int          spacing;

  initial begin
    nib_exp     = '{4'h1, 4'h2, 4'h3, 4'h4};
    spacing     =
`ifdef TRACER_HOST_OVERLAP_EN
      8;
`else
      9;
`endif
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_abs     = 1'b0;
    req_operand = 16'd0;
    rsp_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    check_val("rst_dut_reset", dut_reset, 1);
    check_val("rst_dut_abs", dut_abs, 0);
    check_val("rst_dut_data", dut_data, 0);
    check_val("rst_state", dbg_state, IDLE);
    reset = 1'b0;

    // nibble order
    drive_req(16'h1234, 1'b0, recip_ref(16'h1234, 1'b0), 1'b0, e0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("send_nibble", dut_data, nib_exp[k]);
      check_val("send_dut_reset", dut_reset, 0);
      check_val("send_state", dbg_state, SEND);
    end
    @(negedge clk);
    check_val("calc_dut_data", dut_data, 0);
    check_val("calc_dut_reset", dut_reset, 0);
    wait_rsp();

    // known reciprocals
    drive_req(16'h0400, 1'b0, 16'h0400, 1'b0, e0); wait_rsp();
    drive_req(16'h0200, 1'b0, 16'h0800, 1'b0, e0); wait_rsp();
    drive_req(16'h0800, 1'b0, 16'h0200, 1'b0, e0); wait_rsp();

    // backpressure
    rsp_ready = 1'b0;
    drive_req(16'h0200, 1'b0, 16'h0800, 1'b0, e0);
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    check_val("bp_valid_seen", rsp_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("bp_rsp_valid", rsp_valid, 1);
      check_val("bp_rsp_data", rsp_data, 16'h0800);
      check_val("bp_req_ready", req_ready, 0);
      check_val("bp_dut_reset", dut_reset, 1);
    end
    rsp_ready = 1'b1;
    wait_rsp();
    drive_req(16'h0800, 1'b0, 16'h0200, 1'b0, e0); wait_rsp();

    // reset while in CALC
    drive_req(16'h0800, 1'b0, 16'h0200, 1'b0, e0);
    repeat (5) @(negedge clk);
    check_val("pre_rst_state", dbg_state, CALC);
    reset = 1'b1;
    @(negedge clk);
    check_val("midrst_state", dbg_state, IDLE);
    check_val("midrst_rsp_valid", rsp_valid, 0);
    check_val("midrst_dut_reset", dut_reset, 1);
    check_val("midrst_req_ready", req_ready, 1);
    reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    drive_req(16'h0400, 1'b0, 16'h0400, 1'b0, e0); wait_rsp();

    // abs mode with a negative operand
    drive_req(16'hFC00, 1'b1, 16'h0400, 1'b0, e0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check_val("abs_held", dut_abs, 1);
    end
    @(negedge clk);
    check_val("abs_done_clear", dut_abs, 0);
    check_val("abs_done_dut_reset", dut_reset, 1);
    wait_rsp();

    // back-to-back with req_valid held high
    drive_req(16'h0400, 1'b0, 16'h0400, 1'b1, e0);
    drive_req(16'h0200, 1'b0, 16'h0800, 1'b1, e1);
    check_val("b2b_spacing", 32'(e1 - e0), 32'(spacing));
    drive_req(16'h0800, 1'b0, 16'h0200, 1'b1, e0);
    check_val("b2b_spacing", 32'(e0 - e1), 32'(spacing));
    op = 16'(($urandom_range(16'h0100, 16'h7FFF)));
    drive_req(op, 1'b0, recip_ref(op, 1'b0), 1'b0, e1);
    check_val("b2b_spacing", 32'(e1 - e0), 32'(spacing));
    wait_rsp();

    // random operands, random gaps
    for (int i = 0; i < 8; i++) begin
      op = 16'($urandom_range(0, 65535));
      ab = 1'($urandom_range(0, 1));
      drive_req(op, ab, recip_ref(op, ab), 1'b0, e0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wait_rsp();
    end

    repeat (5) @(negedge clk);
    check_val("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
